// File: rtl/decoder_seq_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
// Imported by decoder_seq and its testbench-facing top.
package decoder_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int MAX_OUTS = 256;

  function automatic logic [MAX_OUTS-1:0] onehot(
    input int unsigned idx,
    input int unsigned width
  );
    logic [MAX_OUTS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_OUTS; i++) begin
      v[i] = (i == idx) && (i < width);
    end
    return v;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Free-running dwell counter; tick marks the last cycle of a dwell.
// Wraps to zero on tick and holds zero while cleared.
module dwell_counter #(
  parameter int DWELL = 4,
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered binary-to-one-hot decoder with direct and scan modes.
// Polarity is folded into z_q so the pins come straight off flops.
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel,
  output logic                  sel_ready,
  output logic [2**SEL_W-1:0]   z,
  output logic                  z_valid,
  output logic [SEL_W-1:0]      index,
  output logic                  wrap
);

  localparam int OUTS  = 2**SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [OUTS-1:0] Z_OFF = {OUTS{ACTIVE_LOW != 0}};

  function automatic logic [OUTS-1:0] decode(
    input logic [SEL_W-1:0] i
  );
    logic [MAX_OUTS-1:0] oh;
    oh = onehot(32'(i), OUTS);
    return oh[OUTS-1:0] ^ Z_OFF;
  endfunction

  state_e state_q;
  state_e state_d;

  logic [OUTS-1:0]  z_q;
  logic [OUTS-1:0]  z_d;
  logic             z_valid_q;
  logic             z_valid_d;
  logic [SEL_W-1:0] index_q;
  logic [SEL_W-1:0] index_d;
  logic             wrap_q;
  logic             wrap_d;

  logic             accept;
  logic             scanning;
  logic             tick;
  logic [SEL_W-1:0] next_idx;

  assign sel_ready = en & (mode == MODE_DIRECT) & ~rst;
  assign accept    = sel_valid & sel_ready;
  assign scanning  = en & (mode == MODE_SCAN)
                   & (state_q == ST_SCAN);
  assign next_idx  = index_q + SEL_W'(1);

  dwell_counter #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (~scanning),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      z_q       <= Z_OFF;
      z_valid_q <= 1'b0;
      index_q   <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      index_q   <= index_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
    end
  end

  always_comb begin
    z_d       = z_q;
    z_valid_d = z_valid_q;
    index_d   = index_q;
    wrap_d    = 1'b0;
    if (!en) begin
      z_d       = Z_OFF;
      z_valid_d = 1'b0;
      index_d   = '0;
    end else if (mode == MODE_SCAN) begin
      // Entering scan from any other state restarts at line 0
      if (state_q != ST_SCAN) begin
        z_d       = decode('0);
        z_valid_d = 1'b1;
        index_d   = '0;
      end else if (tick) begin
        z_d     = decode(next_idx);
        index_d = next_idx;
        wrap_d  = &index_q;
      end
    end else if (accept) begin
      z_d       = decode(sel);
      z_valid_d = 1'b1;
      index_d   = sel;
    end
  end

  assign z       = z_q;
  assign z_valid = z_valid_q;
  assign index   = index_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq across three parameter sets.
// Expected outputs for instance A flow through a scoreboard queue.
module tb_decoder_seq;

  typedef struct {
    logic [3:0] z;
    logic       v;
    logic [1:0] idx;
    logic       w;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_en, a_mode, a_sel_valid;
  logic [1:0] a_sel;
  logic       a_sel_ready, a_z_valid, a_wrap;
  logic [3:0] a_z;
  logic [1:0] a_index;

  logic       b_rst, b_en, b_mode, b_sel_valid;
  logic [2:0] b_sel;
  logic       b_sel_ready, b_z_valid, b_wrap;
  logic [7:0] b_z;
  logic [2:0] b_index;

  logic       c_rst, c_en, c_mode, c_sel_valid;
  logic [1:0] c_sel;
  logic       c_sel_ready, c_z_valid, c_wrap;
  logic [3:0] c_z;
  logic [1:0] c_index;

  decoder_seq #(.SEL_W(2), .DWELL(3), .ACTIVE_LOW(0)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode),
    .sel_valid(a_sel_valid), .sel(a_sel),
    .sel_ready(a_sel_ready), .z(a_z), .z_valid(a_z_valid),
    .index(a_index), .wrap(a_wrap)
  );

  decoder_seq #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode),
    .sel_valid(b_sel_valid), .sel(b_sel),
    .sel_ready(b_sel_ready), .z(b_z), .z_valid(b_z_valid),
    .index(b_index), .wrap(b_wrap)
  );

  decoder_seq #(.SEL_W(2), .DWELL(1), .ACTIVE_LOW(0)) u_c (
    .clk(clk), .rst(c_rst), .en(c_en), .mode(c_mode),
    .sel_valid(c_sel_valid), .sel(c_sel),
    .sel_ready(c_sel_ready), .z(c_z), .z_valid(c_z_valid),
    .index(c_index), .wrap(c_wrap)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [3:0] z, input logic v,
                        input logic [1:0] idx, input logic w);
    exp_t e;
    e.z = z; e.v = v; e.idx = idx; e.w = w;
    sbq.push_back(e);
  endtask

  task automatic cmp_a(input string tag);
    exp_t e;
    n_tests++;
    assert (sbq.size() > 0) else begin
      n_fail++;
      $error("FAIL %s: got empty scoreboard expected entry", tag);
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_z"},   32'(a_z),       32'(e.z));
      chk({tag, "_v"},   32'(a_z_valid), 32'(e.v));
      chk({tag, "_idx"}, 32'(a_index),   32'(e.idx));
      chk({tag, "_w"},   32'(a_wrap),    32'(e.w));
    end
  endtask

  task automatic tick_a(input string tag, input logic [3:0] z,
                        input logic v, input logic [1:0] idx,
                        input logic w);
    push_a(z, v, idx, w);
    step();
    cmp_a(tag);
  endtask

  initial begin
    int idx;
    logic w;
    a_rst = 1; a_en = 0; a_mode = 0; a_sel_valid = 0; a_sel = 0;
    b_rst = 1; b_en = 0; b_mode = 0; b_sel_valid = 0; b_sel = 0;
    c_rst = 1; c_en = 0; c_mode = 0; c_sel_valid = 0; c_sel = 0;
    push_a(4'b0000, 0, 0, 0);
    step();
    step();
    cmp_a("a_reset");
    chk("b_reset_z", 32'(b_z), 32'hFF);
    chk("c_reset_z", 32'(c_z), 32'h0);

    a_en = 1;
    #1;
    chk("a_ready_in_rst", 32'(a_sel_ready), 32'd0);
    a_rst = 0; b_rst = 0; c_rst = 0;
    #1;
    chk("a_ready_direct", 32'(a_sel_ready), 32'd1);
    tick_a("a_idle_to_direct", 4'b0000, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      a_sel = 2'(i);
      a_sel_valid = 1;
      tick_a($sformatf("a_direct%0d", i),
             4'(1 << i), 1, 2'(i), 0);
    end
    a_sel_valid = 0;
    tick_a("a_hold", 4'b1000, 1, 3, 0);
    a_sel = 3; a_sel_valid = 1;
    tick_a("a_repeat", 4'b1000, 1, 3, 0);

    a_mode = 1; a_sel = 1;
    #1;
    chk("a_ready_scan", 32'(a_sel_ready), 32'd0);
    for (int k = 0; k < 20; k++) begin
      idx = (k / 3) % 4;
      w = (k > 0) && (k % 3 == 0) && (idx == 0);
      tick_a($sformatf("a_scan%0d", k),
             4'(1 << idx), 1, 2'(idx), w);
    end

    a_sel_valid = 0; a_mode = 0;
    #1;
    chk("a_ready_mode_fall", 32'(a_sel_ready), 32'd1);
    tick_a("a_sw_hold0", 4'b0100, 1, 2, 0);
    tick_a("a_sw_hold1", 4'b0100, 1, 2, 0);
    a_sel = 1; a_sel_valid = 1;
    tick_a("a_sw_accept", 4'b0010, 1, 1, 0);
    a_sel = 3; a_mode = 1;
    tick_a("a_rescan", 4'b0001, 1, 0, 0);
    a_sel_valid = 0;
    tick_a("a_rescan_c1", 4'b0001, 1, 0, 0);

    a_en = 0;
    tick_a("a_en_drop", 4'b0000, 0, 0, 0);
    tick_a("a_en_idle", 4'b0000, 0, 0, 0);
    a_en = 1;
    tick_a("a_en_back", 4'b0001, 1, 0, 0);
    a_mode = 0;
    tick_a("a_to_direct", 4'b0001, 1, 0, 0);
    a_sel = 2; a_sel_valid = 1; a_rst = 1;
    #1;
    chk("a_ready_rst_mid", 32'(a_sel_ready), 32'd0);
    tick_a("a_rst_accept", 4'b0000, 0, 0, 0);
    a_rst = 0; a_sel_valid = 0;
    tick_a("a_post_rst", 4'b0000, 0, 0, 0);

    b_en = 1;
    step();
    chk("b_direct_idle_z", 32'(b_z), 32'hFF);
    chk("b_direct_idle_v", 32'(b_z_valid), 32'd0);
    b_sel = 5; b_sel_valid = 1;
    step();
    chk("b_sel5_z", 32'(b_z), 32'hDF);
    chk("b_sel5_idx", 32'(b_index), 32'd5);
    chk("b_sel5_v", 32'(b_z_valid), 32'd1);
    b_sel_valid = 0; b_en = 0;
    step();
    chk("b_en_drop_z", 32'(b_z), 32'hFF);
    chk("b_en_drop_v", 32'(b_z_valid), 32'd0);

    c_en = 1; c_mode = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("c_idx%0d", k), 32'(c_index), 32'(k % 4));
      chk($sformatf("c_z%0d", k), 32'(c_z), 32'(1 << (k % 4)));
      chk($sformatf("c_wrap%0d", k), 32'(c_wrap),
          32'((k > 0) && (k % 4 == 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder; successor to the fixed 2-to-4 combinational decoder.
- Two modes:
  - Direct: decodes a handshaked select.
  - Scan: auto-walks the one-hot output across all lines, dwelling a programmable number of cycles on each.
- Drives enable/select lines (LED/digit strobes, bank selects) in board-level designs.

Parameters:
- SEL_W, 2, select width; output count OUTS = 2**SEL_W (local, derived).
- DWELL, 4, cycles each line stays active in scan mode; legal range 1..65535.
- ACTIVE_LOW, 0, 1 = the active line is driven 0 and inactive lines are driven 1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  block enable.
- mode  in  1  0 = direct, 1 = scan.
- sel_valid  in  1  sel is presented.
- sel  in  SEL_W  line index to activate.
- sel_ready  out  1  combinational; equals en & ~mode & ~rst.
- z  out  OUTS  one-hot output, registered; bit k corresponds to index k.
- z_valid  out  1  z currently carries an active line.
- index  out  SEL_W  registered index of the active line.
- wrap  out  1  one-cycle pulse when scan index wraps OUTS-1 -> 0.

Behaviour:
- All outputs are registered except sel_ready. "Inactive" means all zeros, or all ones when ACTIVE_LOW = 1.
- Reset (rst = 1 at an edge; overrides everything):
  - state = IDLE
  - z inactive, z_valid = 0, index = 0, wrap = 0
  - dwell counter = 0
- States: IDLE, DIRECT, SCAN.
- From IDLE:
  - en & ~mode -> DIRECT; z stays inactive until a select is accepted.
  - en & mode -> SCAN; index = 0, z = onehot(0), z_valid = 1, dwell counter = 0.
- DIRECT:
  - Accept on sel_valid & sel_ready. Next cycle: z = onehot(sel), index = sel, z_valid = 1. Latency 1.
  - Without a new accept, z and index hold indefinitely.
  - A repeated identical sel is accepted; outputs are unchanged.
- SCAN:
  - Dwell counter increments every cycle.
  - When it reaches DWELL-1: counter -> 0 and index -> index+1 modulo OUTS; z follows index.
  - On OUTS-1 -> 0, wrap = 1 for exactly the cycle in which index = 0 first appears.
  - DWELL = 1 advances index every cycle.
  - sel_ready = 0 in SCAN; sel is ignored.
- Mode change:
  - SCAN -> DIRECT (mode falls, en = 1): next state DIRECT; z/index/z_valid hold their current values; dwell counter cleared. sel_ready rises in the same cycle mode falls.
  - DIRECT -> SCAN (mode rises): restart at index 0, dwell counter 0, wrap = 0. A sel_valid in the cycle mode rises is not accepted.
- en falls in any state:
  - Next cycle: state = IDLE, z inactive, z_valid = 0, index = 0, wrap = 0.
  - When en returns, behaviour is the same as from IDLE.
- rst asserted mid-scan or mid-handshake: reset values take effect on that edge; no partial update.
- z is always either exactly one active bit (z_valid = 1) or fully inactive (z_valid = 0); never multi-hot.

Decomposition:
- Package decoder_seq_pkg:
  - state enum (IDLE, DIRECT, SCAN)
  - MODE_DIRECT / MODE_SCAN constants
  - function onehot(idx, width) returning the decoded vector
- Sub-module dwell_counter: parametrised width, clear, tick output at DWELL-1. Instantiated once.
- Decode and polarity stay in the top level.

Test Plan:
- Direct decode: SEL_W = 2, ACTIVE_LOW = 0, en = 1, mode = 0; apply sel 0,1,2,3 with sel_valid -> z = 0001, 0010, 0100, 1000, each one cycle after its accept; z_valid = 1; index matches sel.
- Scan with wrap: SEL_W = 2, DWELL = 3, mode = 1 -> index 0,0,0,1,1,1,2,2,2,3,3,3,0 …; wrap high only on the cycle index returns to 0; sel_valid ignored, sel_ready = 0.
- Polarity and width: SEL_W = 3, ACTIVE_LOW = 1, sel = 5 -> z = 8'b1101_1111; after reset z = 8'hFF.
- Mode switch mid-scan: index = 2 at DWELL count 1, mode -> 0 -> z holds onehot(2); sel = 1 accepted the same cycle -> z = 0010 next cycle. mode -> 1 -> z = 0001, index = 0.
- Enable drop and reset: en = 0 mid-scan -> next cycle z = 0000, z_valid = 0. rst pulsed during a sel accept -> no update; outputs at reset values.
- Edge DWELL = 1: mode = 1 -> index increments every cycle; wrap every OUTS cycles.
